fifo_enq_arbiter: RTL and testbench
===================================

# fifo_enq_arbiter

- Round-robin arbiter that shares the enqueue port of one `fifo` among `N_REQ` producers, each with its own ready-valid interface.
- Selection and data steering are combinational, so no latency is added.
- Arbitration state is registered: the round-robin pointer and an optional burst lock.
- Sits directly in front of a `fifo` instance: its `enq_*` outputs drive the fifo's `enq_valid`/`enq_data`, and the fifo's `enq_ready` drives back in.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters (≥2).
- `ENTRY_WIDTH`, 32: data width; matches the fifo's `ENTRY_WIDTH`.
- `MAX_BURST`, 4: maximum consecutive beats granted to one requester while locked (≥1). Used only when burst lock is compiled in.
- `ID_WIDTH`, localparam: `$clog2(N_REQ)`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  N_REQ  per-requester valid.
- `req_data`  in  [N_REQ-1:0][ENTRY_WIDTH-1:0]  per-requester payload.
- `req_ready`  out  N_REQ  one-hot ready; high only for the requester transferring this cycle.
- `enq_valid`  out  1  to fifo `enq_valid`.
- `enq_data`  out  ENTRY_WIDTH  to fifo `enq_data`; equals `req_data[grant_id]`.
- `enq_ready`  in  1  from fifo `enq_ready`.
- `grant_id`  out  ID_WIDTH  index of the currently selected requester (debug/trace).

## Operation

State:
- `last_ptr` (ID_WIDTH) resets to `N_REQ-1`, so requester 0 has first priority.
- With burst lock compiled in, also: `lock_owner` (ID_WIDTH, reset 0), `lock_active` (1, reset 0) and `burst_cnt` (`$clog2(MAX_BURST+1)` bits, reset 0).

Combinational selection:
- If `lock_active` and `req_valid[lock_owner]`: grant `lock_owner`.
- Otherwise grant the first valid requester scanning `last_ptr+1, last_ptr+2, …` modulo `N_REQ`.
- `enq_valid` is the OR of `req_valid`. It never depends on `enq_ready`.
- `req_ready[i] = enq_valid & enq_ready & (grant_id == i)`.
- `grant_id` is 0 when no requester is valid.

Transfer:
- A transfer occurs when `enq_valid & enq_ready`.
- On a transfer, `last_ptr <= grant_id`.
- With no transfer, all state holds, including during fifo full (`enq_ready=0`).

Burst lock, on each transfer:
- If `lock_active` and `grant_id == lock_owner`: `burst_cnt+1`. If that value equals `MAX_BURST`, clear `lock_active` and `burst_cnt`.
- Otherwise: `lock_owner <= grant_id`, `burst_cnt <= 1`, `lock_active <= (MAX_BURST > 1)`.

Boundary conditions:
- **Lock owner drops `req_valid` while locked:** lock is bypassed combinationally that cycle. `lock_active` and `burst_cnt` clear at the next edge whether or not another requester transferred.
- **Requester protocol:** requesters must hold `req_valid`/`req_data` until their `req_ready`. Given that, `grant_id` and `enq_data` are stable across fifo-full stalls.
- **Wrap-around:** the scan past `N_REQ-1` continues at 0. `last_ptr` never leaves the range 0..N_REQ-1.
- **Reset:** while `rst` is high, `enq_valid`, all `req_ready` and `grant_id` are forced to 0. State loads reset values at the edge. Reset mid-burst discards the lock; no transfer occurs in a reset cycle.

## Timing

- Zero-cycle latency: `req_data` reaches `enq_data` in the same cycle.
- Exactly one beat moves per transfer cycle; full throughput of 1 beat/cycle when the fifo is not full.
- Round-robin pointer and lock updates take effect on the cycle after the transfer.
- Fairness: with all requesters continuously valid and the lock compiled out, each is granted once every `N_REQ` transfers. With the lock compiled in, each is granted `MAX_BURST` consecutive transfers per rotation.

## Configuration

- `FIFO_ARB_BURST_LOCK_EN` defined:
  - burst-lock state and logic are present as described;
  - a granted requester keeps the port for up to `MAX_BURST` back-to-back transfers.
- Not defined:
  - `lock_owner`, `lock_active` and `burst_cnt` are absent;
  - arbitration is pure per-beat round-robin from `last_ptr`;
  - `MAX_BURST` is ignored.

## Test plan

- **Reset:** hold `rst` 2 cycles with all `req_valid=1` → `enq_valid=0`, `req_ready=0`. First cycle after reset grants requester 0 (`grant_id=0`, `enq_data=req_data[0]`).
- **Rotation, lock out, N_REQ=4, `enq_ready=1`:** all valid → grants 0,1,2,3,0,1 on successive cycles. Only 1 and 3 valid → 1,3,1,3.
- **Burst, lock in, MAX_BURST=4:** all valid → grants 0,0,0,0,1,1,1,1,2…
- **Lock owner deasserts after beat 2:** next grant is 1. The following cycle shows `lock_active=0` before requester 1 re-locks.
- **Fifo backpressure:** `enq_ready=0` for 5 cycles with requesters 2,3 valid → `grant_id` stays 2, `req_ready=0`, no state change. `enq_ready=1` → requester 2 transfers first.
- **Reset mid-burst:** assert `rst` after 2 locked beats of requester 1 → after release, the grant restarts at requester 0 with `burst_cnt=0`.
- **Integration with an 8-entry fifo, fed by 3 requesters at 10 beats each:** all 30 values are dequeued exactly once with per-requester order preserved, and `enq_valid` is never high with `req_ready` all-zero while `enq_ready=1`.

Source files
------------

// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter: round-robin sharing of one fifo enqueue port among N_REQ ready/valid producers.
// Latency: zero cycles; grant selection and data steering are combinational, only arbitration state is registered.
// Backpressure: fifo enq_ready gates only the granted requester's req_ready; all state holds while stalled.
// Optional burst lock (up to MAX_BURST back-to-back beats per owner) is compiled in by defining FIFO_ARB_BURST_LOCK_EN.
module fifo_enq_arbiter #(
  parameter int  N_REQ       = 4,
  parameter int  ENTRY_WIDTH = 32,
  parameter int  MAX_BURST   = 4,
  localparam int ID_WIDTH    = $clog2(N_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ-1:0][ENTRY_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]                  req_ready,
  output logic                              enq_valid,
  output logic [ENTRY_WIDTH-1:0]            enq_data,
  input  logic                              enq_ready,
  output logic [ID_WIDTH-1:0]               grant_id
);

  // Reject parameter sets the arbitration logic cannot represent.
  if (N_REQ < 2 || MAX_BURST < 1) begin : g_param_check
    $error("fifo_enq_arbiter: N_REQ must be >= 2 and MAX_BURST >= 1");
  end

  logic [ID_WIDTH-1:0] last_ptr_q, last_ptr_d;
  logic [ID_WIDTH-1:0] rr_id;
  logic [ID_WIDTH-1:0] sel_id;
  logic                any_valid;
  logic                xfer;

  // Round-robin scan starting just after the last granted requester; walking
  // the offsets downwards lets the nearest valid requester win the final write.
  always_comb begin
    rr_id = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_valid[(int'(last_ptr_q) + k) % N_REQ]) begin
        rr_id = ID_WIDTH'((int'(last_ptr_q) + k) % N_REQ);
      end
    end
  end

`ifdef FIFO_ARB_BURST_LOCK_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [ID_WIDTH-1:0] lock_owner_q, lock_owner_d;
  logic                lock_active_q, lock_active_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                lock_hit;

  // A live lock only wins while its owner still presents data; otherwise fall back to round-robin.
  assign lock_hit = lock_active_q & req_valid[lock_owner_q];
  assign sel_id   = lock_hit ? lock_owner_q : rr_id;

  // Lock bookkeeping: an owner dropping valid ends the lock outright, otherwise count beats or re-lock on transfer.
  always_comb begin
    lock_owner_d  = lock_owner_q;
    lock_active_d = lock_active_q;
    burst_cnt_d   = burst_cnt_q;
    cnt_inc       = burst_cnt_q + CNT_W'(1);
    if (lock_active_q && !req_valid[lock_owner_q]) begin
      lock_active_d = 1'b0;
      burst_cnt_d   = '0;
    end else if (xfer) begin
      if (lock_active_q && (grant_id == lock_owner_q)) begin
        if (cnt_inc == CNT_W'(MAX_BURST)) begin
          lock_active_d = 1'b0;
          burst_cnt_d   = '0;
        end else begin
          burst_cnt_d = cnt_inc;
        end
      end else begin
        lock_owner_d  = grant_id;
        burst_cnt_d   = CNT_W'(1);
        lock_active_d = (MAX_BURST > 1);
      end
    end
  end

  // Lock state registers; reset discards any burst in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_owner_q  <= '0;
      lock_active_q <= 1'b0;
      burst_cnt_q   <= '0;
    end else begin
      lock_owner_q  <= lock_owner_d;
      lock_active_q <= lock_active_d;
      burst_cnt_q   <= burst_cnt_d;
    end
  end
`else
  assign sel_id = rr_id;
`endif

  // enq_valid never looks at enq_ready, so the fifo sees a stable request during full stalls.
  assign any_valid = |req_valid;
  assign enq_valid = any_valid & ~rst;
  assign grant_id  = enq_valid ? sel_id : '0;
  assign enq_data  = req_data[grant_id];
  assign xfer      = enq_valid & enq_ready;

  // One-hot ready back to the single requester whose beat moves this cycle.
  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign last_ptr_d = xfer ? grant_id : last_ptr_q;

  // Round-robin pointer; resets to the top index so requester 0 is scanned first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_ptr_q <= ID_WIDTH'(N_REQ - 1);
    end else begin
      last_ptr_q <= last_ptr_d;
    end
  end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Directed bench for fifo_enq_arbiter: vector table for reset, rotation, stalls and
// reset mid-stream, followed by a three-producer run into a modelled 8-entry fifo.
module tb_fifo_enq_arbiter;

  localparam int N  = 4;
  localparam int EW = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid;
  logic [N-1:0][EW-1:0] req_data;
  logic [N-1:0]         req_ready;
  logic                 enq_valid;
  logic [EW-1:0]        enq_data;
  logic                 enq_ready;
  logic [1:0]           grant_id;

  fifo_enq_arbiter #(.N_REQ(N), .ENTRY_WIDTH(EW), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .enq_valid (enq_valid),
    .enq_data  (enq_data),
    .enq_ready (enq_ready),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic       rdy;
    logic       ev;
    logic [3:0] rr;
    logic [1:0] gid;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] vl, input logic rd,
                     input logic e, input logic [3:0] rr, input logic [1:0] g);
    vec_t v;
    v.rst = r; v.vld = vl; v.rdy = rd; v.ev = e; v.rr = rr; v.gid = g;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h111;
  endfunction

  // Integration state
  int          sent[3];
  int          rcvd[3];
  logic [31:0] fq[$];
  int          popped;
  int          gi;
  int          id;
  logic        fire;
  logic        deq;
  logic [31:0] cap;
  logic [31:0] val;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    enq_ready = 1'b1;
    for (int i = 0; i < N; i++) req_data[i] = pat(i);

`ifndef FIFO_ARB_BURST_LOCK_EN
    // reset held two cycles with everyone valid
    add(1, 4'b1111, 1, 0, 4'b0000, 2'd0);
    add(1, 4'b1111, 1, 0, 4'b0000, 2'd0);
    // full rotation 0,1,2,3,0,1
    add(0, 4'b1111, 1, 1, 4'b0001, 2'd0);
    add(0, 4'b1111, 1, 1, 4'b0010, 2'd1);
    add(0, 4'b1111, 1, 1, 4'b0100, 2'd2);
    add(0, 4'b1111, 1, 1, 4'b1000, 2'd3);
    add(0, 4'b1111, 1, 1, 4'b0001, 2'd0);
    add(0, 4'b1111, 1, 1, 4'b0010, 2'd1);
    // only 1 and 3 valid: 3,1,3,1 (pointer sits at 1)
    add(0, 4'b1010, 1, 1, 4'b1000, 2'd3);
    add(0, 4'b1010, 1, 1, 4'b0010, 2'd1);
    add(0, 4'b1010, 1, 1, 4'b1000, 2'd3);
    add(0, 4'b1010, 1, 1, 4'b0010, 2'd1);
    // fifo full five cycles with 2,3 valid: grant parks on 2
    for (int i = 0; i < 5; i++) add(0, 4'b1100, 0, 1, 4'b0000, 2'd2);
    add(0, 4'b1100, 1, 1, 4'b0100, 2'd2);
    add(0, 4'b1100, 1, 1, 4'b1000, 2'd3);
    // idle, then wrap-around from pointer 3
    add(0, 4'b0000, 1, 0, 4'b0000, 2'd0);
    add(0, 4'b0001, 0, 1, 4'b0000, 2'd0);
    add(0, 4'b0111, 1, 1, 4'b0001, 2'd0);
    add(0, 4'b0101, 1, 1, 4'b0100, 2'd2);
    add(0, 4'b0101, 1, 1, 4'b0001, 2'd0);
    // reset mid-stream restarts at requester 0
    add(1, 4'b1111, 1, 0, 4'b0000, 2'd0);
    add(0, 4'b1111, 1, 1, 4'b0001, 2'd0);
    add(0, 4'b1111, 1, 1, 4'b0010, 2'd1);
`else
    add(1, 4'b1111, 1, 0, 4'b0000, 2'd0);
    add(1, 4'b1111, 1, 0, 4'b0000, 2'd0);
    // four-beat bursts: 0,0,0,0,1,1,1,1,2,2
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 1, 1, 4'b0001, 2'd0);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 1, 1, 4'b0010, 2'd1);
    add(0, 4'b1111, 1, 1, 4'b0100, 2'd2);
    add(0, 4'b1111, 1, 1, 4'b0100, 2'd2);
    // owner 2 drops after two beats: bypass to 3, lock released, 0 then locks
    add(0, 4'b1011, 1, 1, 4'b1000, 2'd3);
    add(0, 4'b1011, 1, 1, 4'b0001, 2'd0);
    add(0, 4'b1011, 1, 1, 4'b0001, 2'd0);
    // stall mid-burst keeps the owner
    add(0, 4'b1011, 0, 1, 4'b0000, 2'd0);
    add(0, 4'b1011, 1, 1, 4'b0001, 2'd0);
    add(0, 4'b1011, 1, 1, 4'b0001, 2'd0);
    add(0, 4'b1011, 1, 1, 4'b0010, 2'd1);
    add(0, 4'b1011, 1, 1, 4'b0010, 2'd1);
    // reset after two locked beats of requester 1
    add(1, 4'b1111, 1, 0, 4'b0000, 2'd0);
    add(0, 4'b1111, 1, 1, 4'b0001, 2'd0);
    add(0, 4'b1111, 1, 1, 4'b0001, 2'd0);
`endif

    foreach (tbl[i]) begin
      rst       = tbl[i].rst;
      req_valid = tbl[i].vld;
      enq_ready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_enq_valid", i), 64'(enq_valid), 64'(tbl[i].ev));
      check($sformatf("vec%0d_req_ready", i), 64'(req_ready), 64'(tbl[i].rr));
      check($sformatf("vec%0d_grant_id", i), 64'(grant_id), 64'(tbl[i].gid));
      if (tbl[i].ev) check($sformatf("vec%0d_enq_data", i), 64'(enq_data), 64'(pat(int'(tbl[i].gid))));
      @(posedge clk);
      #1;
    end

    // Integration: 3 producers x 10 beats into an 8-entry fifo with random draining
    rst = 1'b1;
    req_valid = '0;
    enq_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    popped = 0;
    for (int i = 0; i < 3; i++) begin sent[i] = 0; rcvd[i] = 0; end
    for (int cyc = 0; cyc < 2000 && popped < 30; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        req_valid[i] = (sent[i] < 10);
        req_data[i]  = {8'(i), 24'(sent[i])};
      end
      req_valid[3] = 1'b0;
      req_data[3]  = '0;
      enq_ready    = (fq.size() < 8);
      @(negedge clk);
      fire = 1'b0;
      deq  = (fq.size() > 0) && ($urandom_range(0, 2) != 0);
      check("int_enq_valid", 64'(enq_valid), 64'(|req_valid));
      if (enq_valid && enq_ready) begin
        gi = int'(grant_id);
        check("int_req_ready_onehot", 64'(req_ready), 64'(4'b0001 << grant_id));
        if (gi < 3) begin
          check("int_enq_data", 64'(enq_data), 64'({8'(gi), 24'(sent[gi])}));
          cap  = enq_data;
          fire = 1'b1;
        end else begin
          check("int_grant_range", 64'(gi), 64'(0));
        end
      end else begin
        check("int_req_ready_idle", 64'(req_ready), 64'(0));
      end
      @(posedge clk);
      #1;
      if (deq) begin
        val = fq.pop_front();
        id  = int'(val[31:24]);
        if (id < 3) begin
          check($sformatf("int_order_req%0d", id), 64'(val[23:0]), 64'(rcvd[id]));
          rcvd[id]++;
        end else begin
          check("int_deq_id", 64'(id), 64'(0));
        end
        popped++;
      end
      if (fire) begin
        fq.push_back(cap);
        sent[gi]++;
      end
    end
    check("int_total_dequeued", 64'(popped), 64'(30));
    for (int i = 0; i < 3; i++) check($sformatf("int_count_req%0d", i), 64'(rcvd[i]), 64'(10));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
